crank_wheel_decoder: RTL
========================

Name: crank_wheel_decoder

Overview:
- Decodes a raw crank-position trigger wheel of N-M teeth (default 60-2) into tooth period, tooth index and sync status.
- Sits directly upstream of the system's GPIO A read port: status_word drives gpio_a_r_external_connection_export, so firmware reads engine position and speed in one 32-bit load.
- Tooth and revolution strobes are also exported for fabric-side consumers.

Parameters:
- TEETH_TOTAL, 60: physical tooth positions on the wheel, including missing ones.
- TEETH_MISSING, 2: consecutive missing teeth forming the gap.
- PERIOD_W, 24: tooth-period counter width; the counter saturates at 2^PERIOD_W-1.
- MIN_PERIOD, 8: edges arriving fewer than MIN_PERIOD cycles after the last accepted edge are glitches and are ignored.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- enable in 1: decoder enable; 0 holds the FSM in IDLE.
- crank_in in 1: raw asynchronous trigger sensor input.
- clear_loss in 1: single-cycle clear of sticky sync_loss.
- tooth_period out PERIOD_W: clk cycles between the last two normal teeth.
- tooth_index out 6: tooth number since the gap (0 = first tooth after the gap).
- sync out 1: decoder is locked to the wheel.
- sync_loss out 1: sticky flag; a lock was lost.
- tooth_strobe out 1: 1-cycle pulse on each accepted edge.
- rev_strobe out 1: 1-cycle pulse on each confirmed gap while synced.
- status_word out 32: {sync, sync_loss, tooth_index[5:0], tooth_period[23:0]}. Bits [23:0] are zero-extended or truncated to PERIOD_W.

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE; all outputs 0; synchronizer flops 0; period counter 0. Reset mid-revolution drops sync without setting sync_loss.
- Input path: 3-flop chain s1,s2,s3; rising edge = s2 & ~s3. Registered outputs and strobes update on the 3rd clk edge after crank_in is first sampled high.
- Period counter: counts cycles since the last accepted edge and saturates. A constant input period of P cycles yields tooth_period = P.
- Accepted edge: detected edge with counter >= MIN_PERIOD (in IDLE, any edge). A rejected edge leaves the counter, FSM and outputs unchanged.
- Gap test: (cnt << 1) >= (prev * 3), computed at PERIOD_W+2 bits, no overflow. prev is the last normal-tooth period.
- FSM states and transitions:
  - IDLE: on an accepted edge, clear the counter and go to MEASURE.
  - MEASURE: on an accepted edge, prev=cnt, tooth_period=cnt, go to HUNT.
  - HUNT:
    - Accepted edge with gap true: tooth_index=0, sync=1, go to SYNCED. tooth_period holds; prev is unchanged.
    - Accepted edge otherwise: prev=tooth_period=cnt.
  - SYNCED, expected gap (tooth_index == TEETH_TOTAL-TEETH_MISSING-1):
    - Gap true: tooth_index=0, rev_strobe=1.
    - Gap false: sync=0, sync_loss=1, go to HUNT; prev=tooth_period=cnt.
  - SYNCED, not the expected gap:
    - Gap true: sync=0, sync_loss=1, go to HUNT.
    - Gap false: tooth_index+1, prev=tooth_period=cnt.
- tooth_strobe pulses on every accepted edge in MEASURE, HUNT and SYNCED.
- Timeout: when the counter reaches 2^PERIOD_W-1 in MEASURE, HUNT or SYNCED, go to IDLE, sync=0, tooth_period=0, tooth_index=0. sync_loss is set only if the FSM was in SYNCED.
- enable=0: synchronous to IDLE next cycle; counter, sync, tooth_index and tooth_period cleared; sync_loss retained; strobes held 0.
- sync_loss: sticky. clear_loss clears it next cycle. If set and clear occur in the same cycle, set wins.
- Edge coincident with timeout: timeout wins; the edge is discarded.

Test Plan:
1. Reset: assert reset 2 cycles with crank_in toggling -> all outputs 0, status_word=32'h0, FSM in IDLE.
2. Lock: 60-2 wheel, normal tooth period 100 cycles, gap edge spacing 300 -> sync=1 and tooth_index=0 on the gap edge; tooth_period=100; tooth_index reaches 57, then wraps to 0 with rev_strobe; status_word=32'h80000064 at index 0.
3. False gap: after lock, insert an extra tooth inside the gap (spacing 100) -> at index 57 the next edge gives sync=0, sync_loss=1, FSM in HUNT; re-lock on the next true gap; clear_loss pulse -> sync_loss=0.
4. Glitch: while synced at index 10, insert a 2-cycle high pulse 3 cycles after an edge -> tooth_index, tooth_period and tooth_strobe unaffected; next real tooth gives index 11.
5. Stall, with PERIOD_W=10: stop crank_in while synced -> after 1023 cycles, sync=0, sync_loss=1, tooth_period=0; the next edge moves the FSM to MEASURE.
6. Enable/clear race: drop enable mid-revolution -> sync=0 next cycle, sync_loss retained; re-enable and assert clear_loss in the same cycle as a false-gap event -> sync_loss=1 (set wins).

Source files
------------

// File: rtl/crank_wheel_if.sv
// Signal bundle between the crank-wheel decoder and its consumers.
// The decoder owns the slave side; the GPIO status port and fabric logic see the master side.
interface crank_wheel_if #(
  parameter int PERIOD_W = 24
);
  logic                enable;
  logic                crank_in;
  logic                clear_loss;
  logic [PERIOD_W-1:0] tooth_period;
  logic [5:0]          tooth_index;
  logic                sync;
  logic                sync_loss;
  logic                tooth_strobe;
  logic                rev_strobe;
  logic [31:0]         status_word;

  modport master (
    output enable, crank_in, clear_loss,
    input  tooth_period, tooth_index, sync, sync_loss, tooth_strobe, rev_strobe, status_word
  );

  modport slave (
    input  enable, crank_in, clear_loss,
    output tooth_period, tooth_index, sync, sync_loss, tooth_strobe, rev_strobe, status_word
  );
endinterface

// File: rtl/crank_wheel_decoder.sv
// Decodes an N-M crank trigger wheel into tooth period, tooth index and sync status,
// packed into one 32-bit status word for the firmware GPIO read port.
module crank_wheel_decoder #(
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2,
  parameter int PERIOD_W      = 24,
  parameter int MIN_PERIOD    = 8
) (
  input logic          clk,
  input logic          reset,
  crank_wheel_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MEASURE, HUNT, SYNCED} state_t;

  localparam logic [PERIOD_W-1:0] CNT_MAX    = '1;
  localparam logic [PERIOD_W-1:0] CNT_MIN    = PERIOD_W'(MIN_PERIOD);
  localparam logic [5:0]          LAST_TOOTH = 6'(TEETH_TOTAL - TEETH_MISSING - 1);

  logic                s1, s2, s3;
  state_t              state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n;
  logic [PERIOD_W-1:0] prev, prev_n;
  logic [PERIOD_W-1:0] period, period_n;
  logic [5:0]          index, index_n;
  logic                sync, sync_n;
  logic                loss, loss_n;
  logic                tooth_stb, tooth_stb_n;
  logic                rev_stb, rev_stb_n;
  logic                loss_set;
  logic                rise, saturated, accepted, gap;
  logic [PERIOD_W+1:0] cnt_x2, prev_x3;
  logic [23:0]         period_field;

  assign rise      = s2 & ~s3;
  assign saturated = (cnt == CNT_MAX);
  assign accepted  = rise && ((state == IDLE) || (cnt >= CNT_MIN));

  // Gap when the current interval is at least 1.5x the last normal tooth; widened so neither side overflows.
  assign cnt_x2  = {1'b0, cnt, 1'b0};
  assign prev_x3 = {2'b00, prev} + {1'b0, prev, 1'b0};
  assign gap     = (cnt_x2 >= prev_x3);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      prev      <= '0;
      period    <= '0;
      index     <= '0;
      sync      <= 1'b0;
      loss      <= 1'b0;
      tooth_stb <= 1'b0;
      rev_stb   <= 1'b0;
    end else begin
      s1        <= bus.crank_in;
      s2        <= s1;
      s3        <= s2;
      state     <= state_n;
      cnt       <= cnt_n;
      prev      <= prev_n;
      period    <= period_n;
      index     <= index_n;
      sync      <= sync_n;
      loss      <= loss_n;
      tooth_stb <= tooth_stb_n;
      rev_stb   <= rev_stb_n;
    end
  end

  // Priority: disable, then timeout (which swallows a coincident edge), then accepted edges.
  always_comb begin
    state_n     = state;
    cnt_n       = saturated ? cnt : cnt + PERIOD_W'(1);
    prev_n      = prev;
    period_n    = period;
    index_n     = index;
    sync_n      = sync;
    tooth_stb_n = 1'b0;
    rev_stb_n   = 1'b0;
    loss_set    = 1'b0;

    if (!bus.enable) begin
      state_n  = IDLE;
      cnt_n    = '0;
      prev_n   = '0;
      period_n = '0;
      index_n  = '0;
      sync_n   = 1'b0;
    end else if ((state != IDLE) && saturated) begin
      state_n  = IDLE;
      loss_set = (state == SYNCED);
      sync_n   = 1'b0;
      period_n = '0;
      index_n  = '0;
    end else if (accepted) begin
      cnt_n       = PERIOD_W'(1);
      tooth_stb_n = (state != IDLE);
      case (state)
        IDLE: state_n = MEASURE;
        MEASURE: begin
          prev_n   = cnt;
          period_n = cnt;
          state_n  = HUNT;
        end
        HUNT: begin
          if (gap) begin
            index_n = '0;
            sync_n  = 1'b1;
            state_n = SYNCED;
          end else begin
            prev_n   = cnt;
            period_n = cnt;
          end
        end
        SYNCED: begin
          if (index == LAST_TOOTH) begin
            if (gap) begin
              index_n   = '0;
              rev_stb_n = 1'b1;
            end else begin
              sync_n   = 1'b0;
              loss_set = 1'b1;
              state_n  = HUNT;
              prev_n   = cnt;
              period_n = cnt;
            end
          end else if (gap) begin
            sync_n   = 1'b0;
            loss_set = 1'b1;
            state_n  = HUNT;
          end else begin
            index_n  = index + 6'd1;
            prev_n   = cnt;
            period_n = cnt;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    loss_n = loss_set | (loss & ~bus.clear_loss);
  end

  generate
    if (PERIOD_W >= 24) begin : g_trunc
      assign period_field = period[23:0];
    end else begin : g_ext
      assign period_field = {{(24-PERIOD_W){1'b0}}, period};
    end
  endgenerate

  assign bus.tooth_period = period;
  assign bus.tooth_index  = index;
  assign bus.sync         = sync;
  assign bus.sync_loss    = loss;
  assign bus.tooth_strobe = tooth_stb;
  assign bus.rev_strobe   = rev_stb;
  assign bus.status_word  = {sync, loss, index, period_field};

endmodule
